// File: rtl/rd_fifo_buf_pkg.sv
// Shared definitions for the prefetch read-FIFO pixel reader: FSM encoding and
// pixels-per-word derivation with its legality check.
package rd_fifo_buf_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRIME = 2'd1,
        ST_RUN   = 2'd2
    } rd_state_t;

    function automatic int calc_ppw(input int data_w, input int pix_w);
        return data_w / pix_w;
    endfunction

    // The word must split into a power-of-two number of whole pixels.
    function automatic bit ppw_legal(input int data_w, input int pix_w);
        int ppw;
        ppw = 0;
        if (pix_w <= 0)
            return 1'b0;
        if ((data_w % pix_w) != 0)
            return 1'b0;
        ppw = data_w / pix_w;
        return (ppw > 0) && ((ppw & (ppw - 1)) == 0);
    endfunction

endpackage

// File: rtl/rd_fifo_buf_pixel_reader_if.sv
// Read port of the prefetch FIFO: head word, head valid and pop request.
// The reader is the master (issues pops); the FIFO is the slave.
interface rd_fifo_buf_pixel_reader_if #(
    parameter int FIFO_DATA_W = 32
);
    logic [FIFO_DATA_W-1:0] fifo_rd_data;
    logic                   fifo_rd_vld;
    logic                   fifo_rd_en;

    modport master (
        input  fifo_rd_data,
        input  fifo_rd_vld,
        output fifo_rd_en
    );

    modport slave (
        output fifo_rd_data,
        output fifo_rd_vld,
        input  fifo_rd_en
    );
endinterface

// File: rtl/rd_fifo_buf_pixel_reader.sv
// Pops wide words from the prefetch read FIFO and unpacks them into a
// frame-aligned pixel stream on display pixel requests, tracking underflow.
//
// state | meaning
// IDLE  | no frame active, no pops
// PRIME | frame started, waiting for the holding register to fill
// RUN   | serving pixels on pix_req until the next frame_start
module rd_fifo_buf_pixel_reader
    import rd_fifo_buf_pkg::*;
#(
    parameter int FIFO_DATA_W = 32,
    parameter int PIX_W       = 16,
    parameter int LINE_PIX    = 1280,
    parameter int CNT_W       = 16
) (
    input  logic                         rd_clk,
    input  logic                         rd_rst,
    input  logic                         i_frame_start,
    input  logic                         i_pix_req,
    output logic [PIX_W-1:0]             o_pix_data,
    output logic                         o_pix_vld,
    output logic                         o_line_end,
    output logic                         o_primed,
    output logic                         o_underflow,
    output logic [CNT_W-1:0]             o_underflow_cnt,
    rd_fifo_buf_pixel_reader_if.master   fifo
);

    localparam int PPW   = calc_ppw(FIFO_DATA_W, PIX_W);
    localparam int IDX_W = (PPW > 1) ? $clog2(PPW) : 1;
    localparam int LC_W  = (LINE_PIX > 1) ? $clog2(LINE_PIX) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PPW - 1);
    localparam logic [LC_W-1:0]  LC_LAST  = LC_W'(LINE_PIX - 1);

    generate
        if (!ppw_legal(FIFO_DATA_W, PIX_W)) begin : g_bad_cfg
            $error("FIFO_DATA_W must be PIX_W times a power of two");
        end
    endgenerate

    rd_state_t              r_state;
    logic [FIFO_DATA_W-1:0] r_hold_data;
    logic                   r_hold_vld;
    logic [IDX_W-1:0]       r_idx;
    logic [LC_W-1:0]        r_line_cnt;
    logic [PIX_W-1:0]       r_pix_data;
    logic                   r_pix_vld;
    logic                   r_line_end;
    logic                   r_primed;
    logic                   r_underflow;
    logic [CNT_W-1:0]       r_underflow_cnt;

    logic                   w_run_req;
    logic                   w_serve;
    logic                   w_starve;
    logic                   w_last_pix;
    logic                   w_consume_last;
    logic                   w_rd_en;
    logic                   w_pop;
    logic [IDX_W-1:0]       w_idx_inc;
    logic [PIX_W-1:0]       w_pix;
    rd_state_t              w_state_nxt;
    logic                   w_hold_vld_nxt;

    always_comb begin
        w_run_req      = (r_state == ST_RUN) && i_pix_req && !i_frame_start;
        w_serve        = w_run_req && r_hold_vld;
        w_starve       = w_run_req && !r_hold_vld;
        w_last_pix     = (r_line_cnt == LC_LAST);
        w_consume_last = w_serve && ((r_idx == IDX_LAST) || w_last_pix);
        w_rd_en        = (r_state != ST_IDLE) && !i_frame_start
                         && (!r_hold_vld || w_consume_last);
        w_pop          = w_rd_en && fifo.fifo_rd_vld;
        w_idx_inc      = (r_idx == IDX_LAST) ? '0 : r_idx + IDX_W'(1);
    end

    // Little-endian unpack: pixel 0 of a word sits in the least-significant bits.
    always_comb begin
        w_pix = '0;
        for (int i = 0; i < PPW; i++) begin
            if (r_idx == IDX_W'(i))
                w_pix = r_hold_data[i*PIX_W +: PIX_W];
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_hold_vld_nxt = r_hold_vld;
        if (i_frame_start) begin
            w_state_nxt    = ST_PRIME;
            w_hold_vld_nxt = 1'b0;
        end else begin
            if (r_state == ST_PRIME && r_hold_vld)
                w_state_nxt = ST_RUN;
            if (w_pop)
                w_hold_vld_nxt = 1'b1;
            else if (w_consume_last)
                w_hold_vld_nxt = 1'b0;
        end
    end

    assign fifo.fifo_rd_en = w_rd_en;

    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            r_state         <= ST_IDLE;
            r_hold_data     <= '0;
            r_hold_vld      <= 1'b0;
            r_idx           <= '0;
            r_line_cnt      <= '0;
            r_pix_data      <= '0;
            r_pix_vld       <= 1'b0;
            r_line_end      <= 1'b0;
            r_primed        <= 1'b0;
            r_underflow     <= 1'b0;
            r_underflow_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_hold_vld <= w_hold_vld_nxt;
            r_primed   <= (w_state_nxt == ST_RUN) && w_hold_vld_nxt;
            r_pix_data <= '0;
            r_pix_vld  <= 1'b0;
            r_line_end <= 1'b0;

            if (i_frame_start) begin
                r_idx           <= '0;
                r_line_cnt      <= '0;
                r_underflow     <= 1'b0;
                r_underflow_cnt <= '0;
            end else begin
                if (w_pop)
                    r_hold_data <= fifo.fifo_rd_data;

                if (w_serve) begin
                    r_pix_data <= w_pix;
                    r_pix_vld  <= 1'b1;
                    r_line_end <= w_last_pix;
                end

                if (w_starve) begin
                    r_underflow <= 1'b1;
                    if (r_underflow_cnt != '1)
                        r_underflow_cnt <= r_underflow_cnt + CNT_W'(1);
                end

                // Starved slots still advance position so the line stays aligned.
                if (w_serve || w_starve) begin
                    if (w_last_pix) begin
                        r_idx      <= '0;
                        r_line_cnt <= '0;
                    end else begin
                        r_idx      <= w_idx_inc;
                        r_line_cnt <= r_line_cnt + LC_W'(1);
                    end
                end
            end
        end
    end

    assign o_pix_data      = r_pix_data;
    assign o_pix_vld       = r_pix_vld;
    assign o_line_end      = r_line_end;
    assign o_primed        = r_primed;
    assign o_underflow     = r_underflow;
    assign o_underflow_cnt = r_underflow_cnt;

endmodule

// File: tb/tb_rd_fifo_buf_pixel_reader.sv
// Directed bench: two readers (16-bit and 2-bit underflow counters, 5-pixel
// lines) share one modelled FIFO whose pops follow reader A.
module tb_rd_fifo_buf_pixel_reader;

    localparam int DW = 32;
    localparam int PW = 16;
    localparam int LP = 5;

    logic rd_clk = 1'b0;
    logic rd_rst = 1'b1;
    logic frame_start = 1'b0;
    logic pix_req = 1'b0;
    logic tb_vld = 1'b0;

    always #5 rd_clk = ~rd_clk;

    rd_fifo_buf_pixel_reader_if #(.FIFO_DATA_W(DW)) if_a ();
    rd_fifo_buf_pixel_reader_if #(.FIFO_DATA_W(DW)) if_b ();

    logic [PW-1:0] a_pix_data, b_pix_data;
    logic          a_pix_vld, b_pix_vld, a_line_end, b_line_end;
    logic          a_primed, b_primed, a_underflow, b_underflow;
    logic [15:0]   a_ucnt;
    logic [1:0]    b_ucnt;

    int errors = 0;
    int checks = 0;

    // FIFO model: word k is presented at the head until popped.
    logic [31:0] fk = 32'd0;

    function automatic logic [31:0] word_of(input logic [31:0] k);
        if (k == 32'd0)
            return 32'hBBBBAAAA;
        return {4'h2, k[11:0], 4'h1, k[11:0]};
    endfunction

    function automatic logic [15:0] pix_of(input logic [31:0] k, input int half);
        logic [31:0] w;
        w = word_of(k);
        return (half != 0) ? w[31:16] : w[15:0];
    endfunction

    assign if_a.fifo_rd_data = word_of(fk);
    assign if_a.fifo_rd_vld  = tb_vld;
    assign if_b.fifo_rd_data = word_of(fk);
    assign if_b.fifo_rd_vld  = tb_vld;

    always @(posedge rd_clk)
        if (if_a.fifo_rd_en === 1'b1 && tb_vld)
            fk <= fk + 32'd1;

    rd_fifo_buf_pixel_reader #(
        .FIFO_DATA_W(DW), .PIX_W(PW), .LINE_PIX(LP), .CNT_W(16)
    ) dut_a (
        .rd_clk(rd_clk), .rd_rst(rd_rst),
        .i_frame_start(frame_start), .i_pix_req(pix_req),
        .o_pix_data(a_pix_data), .o_pix_vld(a_pix_vld), .o_line_end(a_line_end),
        .o_primed(a_primed), .o_underflow(a_underflow), .o_underflow_cnt(a_ucnt),
        .fifo(if_a)
    );

    rd_fifo_buf_pixel_reader #(
        .FIFO_DATA_W(DW), .PIX_W(PW), .LINE_PIX(LP), .CNT_W(2)
    ) dut_b (
        .rd_clk(rd_clk), .rd_rst(rd_rst),
        .i_frame_start(frame_start), .i_pix_req(pix_req),
        .o_pix_data(b_pix_data), .o_pix_vld(b_pix_vld), .o_line_end(b_line_end),
        .o_primed(b_primed), .o_underflow(b_underflow), .o_underflow_cnt(b_ucnt),
        .fifo(if_b)
    );

    task automatic step();
        @(posedge rd_clk);
        #1;
    endtask

    task automatic wait_primed(input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (a_primed === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s_prime_timeout: primed=%b want 1 within 8 cycles", name, a_primed);
        end
    endtask

    task automatic test_reset();
        rd_rst = 1'b1; tb_vld = 1'b1; frame_start = 1'b0; pix_req = 1'b0;
        repeat (2) @(posedge rd_clk);
        #1;
        checks++; if ({a_pix_data, a_pix_vld, a_line_end} !== '0) begin errors++;
            $display("FAIL reset_pix_a: got %h/%b/%b want 0", a_pix_data, a_pix_vld, a_line_end); end
        checks++; if ({a_primed, a_underflow, a_ucnt} !== '0) begin errors++;
            $display("FAIL reset_status_a: primed=%b uf=%b cnt=%0d want 0", a_primed, a_underflow, a_ucnt); end
        checks++; if (if_a.fifo_rd_en !== 1'b0) begin errors++;
            $display("FAIL reset_rd_en: got %b want 0", if_a.fifo_rd_en); end
        checks++; if ({b_pix_data, b_pix_vld, b_line_end, b_primed, b_underflow, b_ucnt, if_b.fifo_rd_en} !== '0) begin errors++;
            $display("FAIL reset_b: data=%h vld=%b le=%b primed=%b uf=%b cnt=%0d en=%b want 0",
                     b_pix_data, b_pix_vld, b_line_end, b_primed, b_underflow, b_ucnt, if_b.fifo_rd_en); end
        rd_rst = 1'b0;
        step();
    endtask

    task automatic test_idle_prime_ignore();
        pix_req = 1'b1;
        #1;
        checks++; if (if_a.fifo_rd_en !== 1'b0) begin errors++;
            $display("FAIL idle_rd_en: got %b want 0", if_a.fifo_rd_en); end
        step();
        checks++; if (a_pix_vld !== 1'b0 || a_underflow !== 1'b0) begin errors++;
            $display("FAIL idle_req_ignored: vld=%b uf=%b want 0/0", a_pix_vld, a_underflow); end
        pix_req = 1'b0; tb_vld = 1'b0; frame_start = 1'b1;
        step();
        frame_start = 1'b0; pix_req = 1'b1;
        #1;
        checks++; if (if_a.fifo_rd_en !== 1'b1) begin errors++;
            $display("FAIL prime_rd_en: got %b want 1", if_a.fifo_rd_en); end
        step();
        checks++; if (a_pix_vld !== 1'b0 || a_underflow !== 1'b0 || a_primed !== 1'b0) begin errors++;
            $display("FAIL prime_req_ignored: vld=%b uf=%b primed=%b want 0/0/0", a_pix_vld, a_underflow, a_primed); end
        pix_req = 1'b0;
    endtask

    task automatic test_prime();
        bit seen;
        tb_vld = 1'b1; frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (a_primed === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        checks++; if (!seen) begin errors++;
            $display("FAIL prime_within_3: primed=%b want 1", a_primed); end
        pix_req = 1'b1;
        step();
        checks++; if (a_pix_vld !== 1'b1 || a_pix_data !== 16'hAAAA) begin errors++;
            $display("FAIL prime_pix0: vld=%b data=%h want 1/aaaa", a_pix_vld, a_pix_data); end
        step();
        checks++; if (a_pix_vld !== 1'b1 || a_pix_data !== 16'hBBBB) begin errors++;
            $display("FAIL prime_pix1: vld=%b data=%h want 1/bbbb", a_pix_vld, a_pix_data); end
        pix_req = 1'b0;
        step();
        checks++; if (a_pix_vld !== 1'b0 || a_pix_data !== 16'h0000 || a_line_end !== 1'b0) begin errors++;
            $display("FAIL prime_idle_out: vld=%b data=%h le=%b want 0/0/0", a_pix_vld, a_pix_data, a_line_end); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] kb, fs;
        logic [15:0] exp_d;
        int p, l;
        frame_start = 1'b1; tb_vld = 1'b1;
        step();
        frame_start = 1'b0;
        wait_primed("b2b");
        kb = fk - 32'd1;
        fs = fk;
        pix_req = 1'b1;
        for (int n = 0; n < 2*LP; n++) begin
            step();
            p = n % LP;
            l = n / LP;
            exp_d = pix_of(kb + 32'(3*l + p/2), p % 2);
            checks++; if (a_pix_vld !== 1'b1 || a_pix_data !== exp_d) begin errors++;
                $display("FAIL b2b_pix%0d: vld=%b data=%h want 1/%h", n, a_pix_vld, a_pix_data, exp_d); end
            checks++; if (a_line_end !== (p == LP-1)) begin errors++;
                $display("FAIL b2b_line_end%0d: got %b want %b", n, a_line_end, (p == LP-1)); end
        end
        pix_req = 1'b0;
        checks++; if (fk - fs !== 32'd6) begin errors++;
            $display("FAIL b2b_pops: got %0d want 6", fk - fs); end
        step();
    endtask

    task automatic test_starve();
        logic [31:0] kb;
        logic [15:0] exp_d;
        int vld_t[11] = '{1, 1, 1, 1, 0, 0, 0, 0, 1, 1, 1};
        int off_t[11] = '{0, 0, 1, 1, 2, -1, -1, -1, -1, 3, 4};
        int half_t[11] = '{0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0};
        int le_t[11] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0};
        int ca_t[11] = '{0, 0, 0, 0, 0, 1, 2, 3, 4, 4, 4};
        int cb_t[11] = '{0, 0, 0, 0, 0, 1, 2, 3, 3, 3, 3};
        frame_start = 1'b1; tb_vld = 1'b1;
        step();
        frame_start = 1'b0;
        wait_primed("starve");
        kb = fk - 32'd1;
        pix_req = 1'b1;
        for (int c = 0; c < 11; c++) begin
            tb_vld = (vld_t[c] != 0);
            step();
            exp_d = (off_t[c] < 0) ? 16'h0000 : pix_of(kb + 32'(off_t[c]), half_t[c]);
            checks++; if (a_pix_vld !== (off_t[c] >= 0) || a_pix_data !== exp_d) begin errors++;
                $display("FAIL starve_pix%0d: vld=%b data=%h want %b/%h", c, a_pix_vld, a_pix_data, (off_t[c] >= 0), exp_d); end
            checks++; if (a_line_end !== (le_t[c] != 0)) begin errors++;
                $display("FAIL starve_line_end%0d: got %b want %0d", c, a_line_end, le_t[c]); end
            checks++; if (a_ucnt !== 16'(ca_t[c]) || a_underflow !== (ca_t[c] != 0)) begin errors++;
                $display("FAIL starve_cnt_a%0d: cnt=%0d uf=%b want %0d", c, a_ucnt, a_underflow, ca_t[c]); end
            checks++; if (b_ucnt !== 2'(cb_t[c]) || b_pix_vld !== a_pix_vld) begin errors++;
                $display("FAIL starve_cnt_b%0d: cnt=%0d vld=%b want %0d/%b", c, b_ucnt, b_pix_vld, cb_t[c], a_pix_vld); end
        end
        pix_req = 1'b0; tb_vld = 1'b1;
        step();
        checks++; if (a_underflow !== 1'b1 || a_ucnt !== 16'd4 || b_ucnt !== 2'd3) begin errors++;
            $display("FAIL starve_sticky: uf=%b cnt_a=%0d cnt_b=%0d want 1/4/3", a_underflow, a_ucnt, b_ucnt); end
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        checks++; if ({a_underflow, a_ucnt, b_underflow, b_ucnt} !== '0) begin errors++;
            $display("FAIL starve_clear: uf_a=%b cnt_a=%0d uf_b=%b cnt_b=%0d want 0", a_underflow, a_ucnt, b_underflow, b_ucnt); end
    endtask

    task automatic test_frame_restart();
        logic [31:0] kb;
        tb_vld = 1'b1;
        wait_primed("restart");
        kb = fk - 32'd1;
        pix_req = 1'b1;
        step();
        checks++; if (a_pix_vld !== 1'b1 || a_pix_data !== pix_of(kb, 0)) begin errors++;
            $display("FAIL restart_first: vld=%b data=%h want 1/%h", a_pix_vld, a_pix_data, pix_of(kb, 0)); end
        frame_start = 1'b1;
        #1;
        checks++; if (if_a.fifo_rd_en !== 1'b0) begin errors++;
            $display("FAIL restart_rd_en: got %b want 0", if_a.fifo_rd_en); end
        step();
        checks++; if (a_pix_vld !== 1'b0 || a_pix_data !== 16'h0000) begin errors++;
            $display("FAIL restart_no_pix: vld=%b data=%h want 0/0", a_pix_vld, a_pix_data); end
        frame_start = 1'b0; pix_req = 1'b0;
        wait_primed("restart2");
        checks++; if (fk !== kb + 32'd2) begin errors++;
            $display("FAIL restart_pop: fifo index %0d want %0d", fk, kb + 32'd2); end
        pix_req = 1'b1;
        step();
        checks++; if (a_pix_vld !== 1'b1 || a_pix_data !== pix_of(kb + 32'd1, 0)) begin errors++;
            $display("FAIL restart_new_word: vld=%b data=%h want 1/%h", a_pix_vld, a_pix_data, pix_of(kb + 32'd1, 0)); end
        pix_req = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_idle_prime_ignore();
        test_prime();
        test_back_to_back();
        test_starve();
        test_frame_restart();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded 200000 time units");
        $fatal(1, "timeout");
    end

endmodule
